// File: rtl/bsg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_arb_pkg
//  Purpose  : Shared types and helpers for the one-hot arbiters.
//             - arb_state_e : arbiter control state (IDLE / GRANT)
//             - wrap_step   : step an index up or down, wrapping modulo width
//  Revision : 1.0 - initial release
// ============================================================================
package bsg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Move idx one place in the scan direction, wrapping inside [0, width-1].
    function automatic int unsigned wrap_step(input int unsigned idx,
                                              input int unsigned width,
                                              input bit          up);
        if (up) begin
            return (idx >= width - 1) ? 0 : idx + 1;
        end else begin
            return (idx == 0) ? width - 1 : idx - 1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_rotate_priority_one_hot.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_rotate_priority_one_hot
//  Purpose  : Combinational rotating priority selector. Picks the first set
//             bit of i_reqs, scanning from i_start in the configured
//             direction and wrapping modulo WIDTH_P.
//  Ports    : i_reqs     - request vector
//             i_start    - index that is examined first
//             o_grant    - one-hot winner (all zeros if no request)
//             o_grant_id - encoded winner index (0 if no request)
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_rotate_priority_one_hot
    import bsg_arb_pkg::*;
#(
    parameter  int unsigned WIDTH_P     = 4,
    parameter  int unsigned LO_TO_HI_P  = 1,
    localparam int unsigned LG_WIDTH_LP = $clog2(WIDTH_P)
) (
    input  logic [WIDTH_P-1:0]     i_reqs,
    input  logic [LG_WIDTH_LP-1:0] i_start,
    output logic [WIDTH_P-1:0]     o_grant,
    output logic [LG_WIDTH_LP-1:0] o_grant_id
);

    // Rotated bit i maps to original index (start + offset + i) mod WIDTH_P.
    // Low-to-high puts the start index at rotated bit 0 and looks for the
    // lowest set bit. High-to-low puts the start index at the top rotated
    // bit and looks for the highest set bit, which walks downward from start.
    localparam logic [LG_WIDTH_LP:0] c_width  = (LG_WIDTH_LP+1)'(WIDTH_P);
    localparam logic [LG_WIDTH_LP:0] c_offset = (LO_TO_HI_P != 0) ? '0 : (LG_WIDTH_LP+1)'(1);

    logic [LG_WIDTH_LP-1:0] w_map [WIDTH_P];
    logic [WIDTH_P-1:0]     w_rot;
    logic [WIDTH_P-1:0]     w_hot;

    always_comb begin : p_rotate
        logic [LG_WIDTH_LP:0] v_sum;
        v_sum = '0;
        w_rot = '0;
        for (int i = 0; i < WIDTH_P; i++) begin
            // start < WIDTH_P and i < WIDTH_P, so one subtraction is enough
            v_sum = {1'b0, i_start} + c_offset + (LG_WIDTH_LP+1)'(i);
            if (v_sum >= c_width) begin
                v_sum = v_sum - c_width;
            end
            w_map[i] = v_sum[LG_WIDTH_LP-1:0];
            w_rot[i] = i_reqs[w_map[i]];
        end
    end

    generate
        if (LO_TO_HI_P != 0) begin : g_lo_to_hi
            // Isolate the lowest set bit.
            assign w_hot = w_rot & (~w_rot + WIDTH_P'(1));
        end else begin : g_hi_to_lo
            logic [WIDTH_P-1:0] w_rev;
            logic [WIDTH_P-1:0] w_rev_hot;

            always_comb begin
                w_rev = '0;
                for (int i = 0; i < WIDTH_P; i++) begin
                    w_rev[i] = w_rot[WIDTH_P-1-i];
                end
            end

            // Highest set bit of w_rot == lowest set bit of its reversal.
            assign w_rev_hot = w_rev & (~w_rev + WIDTH_P'(1));

            always_comb begin
                w_hot = '0;
                for (int i = 0; i < WIDTH_P; i++) begin
                    w_hot[i] = w_rev_hot[WIDTH_P-1-i];
                end
            end
        end
    endgenerate

    // Rotate the winner back into original index space and encode it.
    always_comb begin : p_unrotate
        o_grant    = '0;
        o_grant_id = '0;
        for (int i = 0; i < WIDTH_P; i++) begin
            if (w_hot[i]) begin
                o_grant[w_map[i]] = 1'b1;
                o_grant_id        = w_map[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_arb_round_robin_one_hot.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_arb_round_robin_one_hot
//  Purpose  : Registered one-hot arbiter with round-robin or fixed priority.
//             The grant is held until the consumer accepts it with yumi_i;
//             on acceptance the next winner is registered in the same cycle,
//             giving one grant per cycle under continuous demand.
//  Ports    : clk_i      - clock, rising edge
//             reset_n_i  - synchronous active-low reset
//             reqs_i     - request vector
//             yumi_i     - consumer accepts the current grant (only with v_o)
//             v_o        - grant valid
//             grants_o   - registered one-hot grant, zero when idle
//             grant_id_o - encoded grant index, zero when idle
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_arb_round_robin_one_hot
    import bsg_arb_pkg::*;
#(
    parameter  int unsigned WIDTH_P     = 4,
    parameter  int unsigned LO_TO_HI_P  = 1,
    parameter  int unsigned RR_P        = 1,
    localparam int unsigned LG_WIDTH_LP = $clog2(WIDTH_P)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [WIDTH_P-1:0]     reqs_i,
    input  logic                   yumi_i,
    output logic                   v_o,
    output logic [WIDTH_P-1:0]     grants_o,
    output logic [LG_WIDTH_LP-1:0] grant_id_o
);

    // After reset the index just "before" the top-priority one is recorded
    // as last served, so the first scan starts at the top-priority index.
    localparam logic [LG_WIDTH_LP-1:0] c_reset_last =
        (LO_TO_HI_P != 0) ? LG_WIDTH_LP'(WIDTH_P - 1) : '0;
    localparam logic [LG_WIDTH_LP-1:0] c_fixed_start =
        (LO_TO_HI_P != 0) ? '0 : LG_WIDTH_LP'(WIDTH_P - 1);

    arb_state_e             r_state,    w_state_n;
    logic [WIDTH_P-1:0]     r_grants,   w_grants_n;
    logic [LG_WIDTH_LP-1:0] r_grant_id, w_grant_id_n;
    logic [LG_WIDTH_LP-1:0] r_last,     w_last_n;

    logic [LG_WIDTH_LP-1:0] w_base;
    logic [LG_WIDTH_LP-1:0] w_start;
    logic [WIDTH_P-1:0]     w_win;
    logic [LG_WIDTH_LP-1:0] w_win_id;

    // On acceptance the search must already see the served index as "last",
    // so bypass the register with the grant being accepted.
    assign w_base = (r_state == GRANT && yumi_i) ? r_grant_id : r_last;

    generate
        if (RR_P != 0) begin : g_round_robin
            assign w_start = LG_WIDTH_LP'(wrap_step(32'(w_base), WIDTH_P, LO_TO_HI_P != 0));
        end else begin : g_fixed
            assign w_start = c_fixed_start;
        end
    endgenerate

    bsg_rotate_priority_one_hot #(
        .WIDTH_P    (WIDTH_P),
        .LO_TO_HI_P (LO_TO_HI_P)
    ) u_select (
        .i_reqs     (reqs_i),
        .i_start    (w_start),
        .o_grant    (w_win),
        .o_grant_id (w_win_id)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_grants   <= '0;
            r_grant_id <= '0;
            r_last     <= c_reset_last;
        end else begin
            r_state    <= w_state_n;
            r_grants   <= w_grants_n;
            r_grant_id <= w_grant_id_n;
            r_last     <= w_last_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_grants_n   = r_grants;
        w_grant_id_n = r_grant_id;
        w_last_n     = r_last;
        case (r_state)
            IDLE: begin
                if (|reqs_i) begin
                    w_state_n    = GRANT;
                    w_grants_n   = w_win;
                    w_grant_id_n = w_win_id;
                end
            end
            GRANT: begin
                // Grant is held regardless of reqs_i until it is accepted.
                if (yumi_i) begin
                    if (RR_P != 0) begin
                        w_last_n = r_grant_id;
                    end
                    if (|reqs_i) begin
                        w_grants_n   = w_win;
                        w_grant_id_n = w_win_id;
                    end else begin
                        w_state_n    = IDLE;
                        w_grants_n   = '0;
                        w_grant_id_n = '0;
                    end
                end
            end
            default: begin
                w_state_n    = IDLE;
                w_grants_n   = '0;
                w_grant_id_n = '0;
            end
        endcase
    end

    assign v_o        = (r_state == GRANT);
    assign grants_o   = r_grants;
    assign grant_id_o = r_grant_id;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o));
            assert ($onehot0(r_grants));
            assert (v_o == (|r_grants));
            assert (!v_o || (r_grants == (WIDTH_P'(1) << r_grant_id)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_arb_round_robin_one_hot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_arb_round_robin_one_hot
//  Purpose  : Directed bench for bsg_arb_round_robin_one_hot. Three instances
//             share stimulus: [0] round-robin low-to-high, [1] fixed
//             low-to-high, [2] round-robin high-to-low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_arb_round_robin_one_hot;

    logic       r_clk;
    logic       r_reset_n;
    logic [3:0] r_reqs;
    logic       r_yumi;

    logic       w_v  [3];
    logic [3:0] w_g  [3];
    logic [1:0] w_id [3];

    int n_vec;
    int n_miss;

    bsg_arb_round_robin_one_hot #(.WIDTH_P(4), .LO_TO_HI_P(1), .RR_P(1)) u_dut_rr (
        .clk_i(r_clk), .reset_n_i(r_reset_n), .reqs_i(r_reqs), .yumi_i(r_yumi),
        .v_o(w_v[0]), .grants_o(w_g[0]), .grant_id_o(w_id[0]));

    bsg_arb_round_robin_one_hot #(.WIDTH_P(4), .LO_TO_HI_P(1), .RR_P(0)) u_dut_fix (
        .clk_i(r_clk), .reset_n_i(r_reset_n), .reqs_i(r_reqs), .yumi_i(r_yumi),
        .v_o(w_v[1]), .grants_o(w_g[1]), .grant_id_o(w_id[1]));

    bsg_arb_round_robin_one_hot #(.WIDTH_P(4), .LO_TO_HI_P(0), .RR_P(1)) u_dut_h2l (
        .clk_i(r_clk), .reset_n_i(r_reset_n), .reqs_i(r_reqs), .yumi_i(r_yumi),
        .v_o(w_v[2]), .grants_o(w_g[2]), .grant_id_o(w_id[2]));

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_arb(input int sel, input string tag,
                           input logic ev, input logic [3:0] eg, input logic [1:0] eid);
        string t;
        t = $sformatf("%s[%0d]", tag, sel);
        chk({t, ".v"},  32'(w_v[sel]),  32'(ev));
        chk({t, ".g"},  32'(w_g[sel]),  32'(eg));
        chk({t, ".id"}, 32'(w_id[sel]), 32'(eid));
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_reset_n = 1'b0;
        r_reqs    = 4'b0000;
        r_yumi    = 1'b0;
        tick();
        tick();
        r_reset_n = 1'b1;
    endtask

    // Accept the final grant with no requests pending; all return to idle.
    task automatic drain(input string tag);
        r_reqs = 4'b0000;
        r_yumi = 1'b1;
        tick();
        r_yumi = 1'b0;
        for (int s = 0; s < 3; s++) chk_arb(s, tag, 1'b0, 4'b0000, 2'd0);
    endtask

    logic [3:0] e_g  [3][4];
    logic [1:0] e_id [3][4];

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // ---- reset state and idle with no requests ----
        do_reset();
        for (int s = 0; s < 3; s++) chk_arb(s, "rst", 1'b0, 4'b0000, 2'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int s = 0; s < 3; s++) chk_arb(s, "idle", 1'b0, 4'b0000, 2'd0);
        end

        // ---- all requesting, continuous accept, includes wrap ----
        r_reqs = 4'b1111;
        #1;
        for (int s = 0; s < 3; s++) chk_arb(s, "lat0", 1'b0, 4'b0000, 2'd0);
        tick();
        chk_arb(0, "all0", 1'b1, 4'b0001, 2'd0);
        chk_arb(1, "all0", 1'b1, 4'b0001, 2'd0);
        chk_arb(2, "all0", 1'b1, 4'b1000, 2'd3);
        e_g[0]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        e_id[0] = '{2'd1, 2'd2, 2'd3, 2'd0};
        e_g[1]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        e_id[1] = '{2'd0, 2'd0, 2'd0, 2'd0};
        e_g[2]  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        e_id[2] = '{2'd2, 2'd1, 2'd0, 2'd3};
        r_yumi = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int s = 0; s < 3; s++) chk_arb(s, $sformatf("all%0d", c + 1), 1'b1, e_g[s][c], e_id[s][c]);
        end
        drain("all_drain");

        // ---- grant held without accept, even after request drops ----
        do_reset();
        r_reqs = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_arb(0, $sformatf("hold%0d", c), 1'b1, 4'b0010, 2'd1);
            chk_arb(1, $sformatf("hold%0d", c), 1'b1, 4'b0010, 2'd1);
            chk_arb(2, $sformatf("hold%0d", c), 1'b1, 4'b0100, 2'd2);
            if (c == 1) r_reqs = 4'b0100;
        end
        r_yumi = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) chk_arb(s, "hold_acc", 1'b1, 4'b0100, 2'd2);
        drain("hold_drain");

        // ---- fixed priority starves bit 3; round-robin alternates ----
        do_reset();
        r_reqs = 4'b1010;
        tick();
        e_g[0]  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        e_id[0] = '{2'd1, 2'd3, 2'd1, 2'd3};
        e_g[2]  = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        e_id[2] = '{2'd3, 2'd1, 2'd3, 2'd1};
        for (int c = 0; c < 4; c++) begin
            if (c == 1) r_yumi = 1'b1;
            if (c > 0) tick();
            chk_arb(0, $sformatf("fix%0d", c), 1'b1, e_g[0][c], e_id[0][c]);
            chk_arb(1, $sformatf("fix%0d", c), 1'b1, 4'b0010, 2'd1);
            chk_arb(2, $sformatf("fix%0d", c), 1'b1, e_g[2][c], e_id[2][c]);
        end
        drain("fix_drain");

        // ---- high-to-low alternation on 1001 ----
        do_reset();
        r_reqs = 4'b1001;
        tick();
        e_g[2]  = '{4'b1000, 4'b0001, 4'b1000, 4'b0000};
        e_id[2] = '{2'd3, 2'd0, 2'd3, 2'd0};
        e_g[0]  = '{4'b0001, 4'b1000, 4'b0001, 4'b0000};
        e_id[0] = '{2'd0, 2'd3, 2'd0, 2'd0};
        for (int c = 0; c < 3; c++) begin
            if (c == 1) r_yumi = 1'b1;
            if (c > 0) tick();
            chk_arb(2, $sformatf("h2l%0d", c), 1'b1, e_g[2][c], e_id[2][c]);
            chk_arb(0, $sformatf("h2l%0d", c), 1'b1, e_g[0][c], e_id[0][c]);
            chk_arb(1, $sformatf("h2l%0d", c), 1'b1, 4'b0001, 2'd0);
        end
        drain("h2l_drain");

        // ---- reset while a grant is outstanding ----
        do_reset();
        r_reqs = 4'b0100;
        tick();
        for (int s = 0; s < 3; s++) chk_arb(s, "mid_pre", 1'b1, 4'b0100, 2'd2);
        r_reset_n = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) chk_arb(s, "mid_rst", 1'b0, 4'b0000, 2'd0);
        r_reset_n = 1'b1;
        r_reqs    = 4'b1111;
        tick();
        chk_arb(0, "mid_post", 1'b1, 4'b0001, 2'd0);
        chk_arb(1, "mid_post", 1'b1, 4'b0001, 2'd0);
        chk_arb(2, "mid_post", 1'b1, 4'b1000, 2'd3);
        drain("mid_drain");

        // ---- single requester granted every cycle ----
        do_reset();
        r_reqs = 4'b0010;
        tick();
        r_yumi = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int s = 0; s < 3; s++) chk_arb(s, $sformatf("one%0d", c), 1'b1, 4'b0010, 2'd1);
        end
        drain("one_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
